// File: rtl/z80_bus_mem_model_if.sv
// CPU-side bus bundle between a tv80 core and the bench memory model.
// master = CPU pins, slave = memory/IO responder.
interface z80_bus_mem_model_if #(
    parameter int ADDR_W = 16
);
    logic              mreq_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic [ADDR_W-1:0] A;
    logic [7:0]        dout;
    logic [7:0]        di;
    logic              wait_n;

    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, A, dout,
        input  di, wait_n
    );

    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, A, dout,
        output di, wait_n
    );
endinterface

// File: rtl/z80_bus_mem_model.sv
// Byte-array memory/IO responder for tv80 benches: wait-state insertion
// and an ordered trace FIFO of every committed CPU write.
module z80_bus_mem_model #(
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] IO_PAGE     = 8'h10,
    parameter int         WAIT_CYCLES = 0,
    parameter int         TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    z80_bus_mem_model_if.slave             bus,
    output logic                           trace_valid,
    output logic [ADDR_W-1:0]              trace_addr,
    output logic [7:0]                     trace_data,
    output logic                           trace_io,
    input  logic                           trace_pop,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] fifo_addr [TRACE_DEPTH];
    logic [7:0]        fifo_data [TRACE_DEPTH];
    logic              fifo_io   [TRACE_DEPTH];

    logic [ADDR_W-1:0] io_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              req;
    logic              commit;
    logic              full;
    logic              pop;
    logic              push_ok;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wait_q, wait_d;
    logic [7:0]    rd_mem_q, rd_mem_d;
    logic [7:0]    rd_io_q, rd_io_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        io_addr       = '0;
        io_addr[15:8] = IO_PAGE;
        io_addr[7:0]  = bus.A[7:0];
        wr_addr       = bus.iorq_n ? bus.A : io_addr;
        req           = (~bus.mreq_n | ~bus.iorq_n) & (~bus.rd_n | ~bus.wr_n);
        rd_mem_d      = mem[bus.A];
        rd_io_d       = mem[io_addr];
    end

    // Write commits only on the edge that enters DONE, so a long wr_n
    // pulse still yields one array write and one trace entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        wait_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        commit  = ~bus.wr_n;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                    wait_d  = 1'b1;
                    commit  = ~bus.wr_n;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                wait_d = 1'b1;
                if (bus.mreq_n && bus.iorq_n) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 1'b1;
            end
        endcase
    end

    always_comb begin
        full    = (count_q == CW'(TRACE_DEPTH));
        pop     = trace_pop & (count_q != '0);
        push_ok = commit & (~full | pop);
        ovf_d   = ovf_q | (commit & full & ~pop);
        wp_d    = wp_q + PW'(push_ok);
        rp_d    = rp_q + PW'(pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wait_q   <= 1'b1;
            rd_mem_q <= '0;
            rd_io_q  <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            rd_mem_q <= rd_mem_d;
            rd_io_q  <= rd_io_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never cleared; reset only blocks a pending commit.
    always_ff @(negedge clk or negedge reset_n) begin
        if (reset_n) begin
            if (commit) begin
                mem[wr_addr] <= bus.dout;
            end
            if (push_ok) begin
                fifo_addr[wp_q] <= wr_addr;
                fifo_data[wp_q] <= bus.dout;
                fifo_io[wp_q]   <= ~bus.iorq_n;
            end
        end
    end

    assign bus.di         = bus.iorq_n ? rd_mem_q : rd_io_q;
    assign bus.wait_n     = wait_q;
    assign trace_valid    = (count_q != '0);
    assign trace_addr     = fifo_addr[rp_q];
    assign trace_data     = fifo_data[rp_q];
    assign trace_io       = fifo_io[rp_q];
    assign trace_count    = count_q;
    assign trace_overflow = ovf_q;
endmodule

// File: tb/tb_z80_bus_mem_model.sv
// Directed bench: two responders (no wait states / two wait states,
// 4-deep trace) driven by the same CPU-style bus cycles.
module tb_z80_bus_mem_model;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mreq_n = 1'b1;
    logic        iorq_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        pop_a = 1'b0;
    logic        pop_b = 1'b0;

    logic        va, vb, ioa, iob, ova, ovb;
    logic [15:0] ada, adb;
    logic [7:0]  dta, dtb;
    logic [2:0]  cna, cnb;

    int n_checks = 0;
    int n_errors = 0;
    int la, lb;
    logic [7:0] ra, rb;

    z80_bus_mem_model_if #(.ADDR_W(16)) bus_a ();
    z80_bus_mem_model_if #(.ADDR_W(16)) bus_b ();

    assign bus_a.mreq_n = mreq_n;
    assign bus_a.iorq_n = iorq_n;
    assign bus_a.rd_n   = rd_n;
    assign bus_a.wr_n   = wr_n;
    assign bus_a.A      = a;
    assign bus_a.dout   = dout;
    assign bus_b.mreq_n = mreq_n;
    assign bus_b.iorq_n = iorq_n;
    assign bus_b.rd_n   = rd_n;
    assign bus_b.wr_n   = wr_n;
    assign bus_b.A      = a;
    assign bus_b.dout   = dout;

    z80_bus_mem_model #(
        .ADDR_W(16), .IO_PAGE(8'h10), .WAIT_CYCLES(0), .TRACE_DEPTH(4)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .trace_valid(va), .trace_addr(ada), .trace_data(dta),
        .trace_io(ioa), .trace_pop(pop_a), .trace_count(cna),
        .trace_overflow(ova)
    );

    z80_bus_mem_model #(
        .ADDR_W(16), .IO_PAGE(8'h10), .WAIT_CYCLES(2), .TRACE_DEPTH(4)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .trace_valid(vb), .trace_addr(adb), .trace_data(dtb),
        .trace_io(iob), .trace_pop(pop_b), .trace_count(cnb),
        .trace_overflow(ovb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle held 6 clocks; counts wait_n-low clocks per DUT.
    // With pop set, each DUT's trace_pop covers exactly its commit edge.
    task automatic cycle(input bit io, input bit wr, input logic [15:0] addr,
                         input logic [7:0] d, input bit pop,
                         output int lo_a, output int lo_b,
                         output logic [7:0] rd_a, output logic [7:0] rd_b);
        @(posedge clk);
        a = addr;
        dout = d;
        if (io) iorq_n = 1'b0;
        else mreq_n = 1'b0;
        if (wr) wr_n = 1'b0;
        else rd_n = 1'b0;
        pop_a = pop;
        lo_a = 0;
        lo_b = 0;
        rd_a = 8'h00;
        rd_b = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (!bus_a.wait_n) lo_a++;
            if (!bus_b.wait_n) lo_b++;
            if (i == 0) pop_a = 1'b0;
            if (i == 1) pop_b = pop;
            if (i == 2) pop_b = 1'b0;
            if (i == 5) begin
                rd_a = bus_a.di;
                rd_b = bus_b.di;
            end
        end
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic pop_both();
        @(posedge clk);
        pop_a = 1'b1;
        pop_b = 1'b1;
        @(posedge clk);
        pop_a = 1'b0;
        pop_b = 1'b0;
    endtask

    task automatic head(input string tag, input logic [15:0] ad,
                        input logic [7:0] dt, input logic io);
        check({tag, "_va"}, 32'(va), 32'd1);
        check({tag, "_vb"}, 32'(vb), 32'd1);
        check({tag, "_addr_a"}, 32'(ada), 32'(ad));
        check({tag, "_addr_b"}, 32'(adb), 32'(ad));
        check({tag, "_data_a"}, 32'(dta), 32'(dt));
        check({tag, "_data_b"}, 32'(dtb), 32'(dt));
        check({tag, "_io_a"}, 32'(ioa), 32'(io));
        check({tag, "_io_b"}, 32'(iob), 32'(io));
    endtask

    initial begin
        u_a.mem[16'hfd0f] = 8'had;
        u_b.mem[16'hfd0f] = 8'had;
        u_a.mem[16'h0034] = 8'h77;
        u_b.mem[16'h0034] = 8'h77;
        u_a.mem[16'h5a34] = 8'h66;
        u_b.mem[16'h5a34] = 8'h66;
        u_a.mem[16'h0200] = 8'h99;
        u_b.mem[16'h0200] = 8'h99;

        repeat (3) @(posedge clk);
        check("rst_di_a", 32'(bus_a.di), 32'h00);
        check("rst_di_b", 32'(bus_b.di), 32'h00);
        check("rst_wait_a", 32'(bus_a.wait_n), 32'd1);
        check("rst_wait_b", 32'(bus_b.wait_n), 32'd1);
        check("rst_valid_a", 32'(va), 32'd0);
        check("rst_valid_b", 32'(vb), 32'd0);
        check("rst_cnt_a", 32'(cna), 32'd0);
        check("rst_cnt_b", 32'(cnb), 32'd0);
        check("rst_ovf_a", 32'(ova), 32'd0);
        check("rst_ovf_b", 32'(ovb), 32'd0);
        @(posedge clk);
        reset_n = 1'b1;

        cycle(1'b0, 1'b0, 16'hfd0f, 8'h00, 1'b0, la, lb, ra, rb);
        check("rd_a", 32'(ra), 32'had);
        check("rd_b", 32'(rb), 32'had);
        check("rd_wait_a", 32'(la), 32'd0);
        check("rd_wait_b", 32'(lb), 32'd2);

        cycle(1'b0, 1'b1, 16'hfd0f, 8'hd6, 1'b0, la, lb, ra, rb);
        check("wr_mem_a", 32'(u_a.mem[16'hfd0f]), 32'hd6);
        check("wr_mem_b", 32'(u_b.mem[16'hfd0f]), 32'hd6);
        check("wr_wait_a", 32'(la), 32'd0);
        check("wr_wait_b", 32'(lb), 32'd2);
        check("wr_cnt_a", 32'(cna), 32'd1);
        check("wr_cnt_b", 32'(cnb), 32'd1);
        head("h1", 16'hfd0f, 8'hd6, 1'b0);

        cycle(1'b1, 1'b1, 16'h5a34, 8'h5a, 1'b0, la, lb, ra, rb);
        check("io_mem_a", 32'(u_a.mem[16'h1034]), 32'h5a);
        check("io_mem_b", 32'(u_b.mem[16'h1034]), 32'h5a);
        check("io_0034_a", 32'(u_a.mem[16'h0034]), 32'h77);
        check("io_5a34_b", 32'(u_b.mem[16'h5a34]), 32'h66);
        check("io_cnt_b", 32'(cnb), 32'd2);

        cycle(1'b1, 1'b0, 16'h0034, 8'h00, 1'b0, la, lb, ra, rb);
        check("io_rd_a", 32'(ra), 32'h5a);
        check("io_rd_b", 32'(rb), 32'h5a);

        @(posedge clk);
        a = 16'h0005;
        mreq_n = 1'b0;
        lb = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            if (!bus_b.wait_n) lb++;
        end
        mreq_n = 1'b1;
        @(posedge clk);
        check("refresh_wait_b", 32'(lb), 32'd0);
        check("refresh_cnt_b", 32'(cnb), 32'd2);

        cycle(1'b0, 1'b1, 16'h0100, 8'h11, 1'b0, la, lb, ra, rb);
        cycle(1'b0, 1'b1, 16'h0101, 8'h22, 1'b0, la, lb, ra, rb);
        check("full_cnt_a", 32'(cna), 32'd4);
        check("full_ovf_b", 32'(ovb), 32'd0);
        cycle(1'b0, 1'b1, 16'h0102, 8'h33, 1'b0, la, lb, ra, rb);
        check("ovf_cnt_a", 32'(cna), 32'd4);
        check("ovf_cnt_b", 32'(cnb), 32'd4);
        check("ovf_a", 32'(ova), 32'd1);
        check("ovf_b", 32'(ovb), 32'd1);
        check("ovf_mem_b", 32'(u_b.mem[16'h0102]), 32'h33);

        head("p1", 16'hfd0f, 8'hd6, 1'b0);
        pop_both();
        head("p2", 16'h1034, 8'h5a, 1'b1);
        pop_both();
        head("p3", 16'h0100, 8'h11, 1'b0);
        pop_both();
        head("p4", 16'h0101, 8'h22, 1'b0);
        pop_both();
        check("drain_va", 32'(va), 32'd0);
        check("drain_vb", 32'(vb), 32'd0);
        check("ovf_sticky_a", 32'(ova), 32'd1);

        @(posedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        check("ovf_clr_a", 32'(ova), 32'd0);
        check("ovf_clr_b", 32'(ovb), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 16'h0300 + 16'(i), 8'ha0 + 8'(i), 1'b0,
                  la, lb, ra, rb);
        end
        cycle(1'b0, 1'b1, 16'h0304, 8'ha4, 1'b1, la, lb, ra, rb);
        check("pp_cnt_a", 32'(cna), 32'd4);
        check("pp_cnt_b", 32'(cnb), 32'd4);
        check("pp_ovf_a", 32'(ova), 32'd0);
        check("pp_ovf_b", 32'(ovb), 32'd0);
        head("pp1", 16'h0301, 8'ha1, 1'b0);
        pop_both();
        pop_both();
        pop_both();
        head("pp_tail", 16'h0304, 8'ha4, 1'b0);

        @(posedge clk);
        a = 16'h0200;
        dout = 8'hee;
        mreq_n = 1'b0;
        wr_n = 1'b0;
        @(posedge clk);
        check("mid_wait_low_b", 32'(bus_b.wait_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_wait_hi_b", 32'(bus_b.wait_n), 32'd1);
        check("mid_cnt_a", 32'(cna), 32'd0);
        check("mid_cnt_b", 32'(cnb), 32'd0);
        check("mid_mem_a", 32'(u_a.mem[16'h0200]), 32'hee);
        check("mid_mem_b", 32'(u_b.mem[16'h0200]), 32'h99);
        @(posedge clk);
        mreq_n = 1'b1;
        wr_n = 1'b1;
        @(posedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        check("post_mem_b", 32'(u_b.mem[16'h0200]), 32'h99);
        check("post_cnt_b", 32'(cnb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
